alu_rs: RTL and testbench

Reservation station that feeds the ALU in the out-of-order core; it is the initiator side of the ALU execute interface. It accepts dispatched ALU/branch/address ops from the decoder, holds them until both operands are known, and snoops result broadcasts from the ALU and LSB to wake up waiting operands. Each cycle it issues at most one ready op to the ALU over a registered execute/type/val1/val2/entry/nowPC bundle.

---
 rtl/alu_rs_pkg.sv | 55 +++++
 rtl/alu_rs_prio_enc.sv | 25 ++
 rtl/alu_rs.sv | 176 +++++++++++++++++
 tb/tb_alu_rs.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// Shared widths, op encodings and entry types for the ALU reservation station.
// Operand snoop helper lives here so dispatch bypass and wakeup use one rule.
package alu_rs_pkg;

    localparam int OP_WIDTH     = 6;
    localparam int VAL_WIDTH    = 32;
    localparam int ROB_ID_WIDTH = 4;
    localparam int TAG_WIDTH    = ROB_ID_WIDTH + 1;
    localparam int ADDR_WIDTH   = 32;

    localparam logic [OP_WIDTH-1:0] OP_ADDI_TYPE = 6'd1;
    localparam logic [OP_WIDTH-1:0] OP_ADD_TYPE  = 6'd2;
    localparam logic [OP_WIDTH-1:0] OP_BEQ_TYPE  = 6'd3;
    localparam logic [OP_WIDTH-1:0] OP_LW_TYPE   = 6'd4;

    typedef struct packed {
        logic                 busy;
        logic [TAG_WIDTH-1:0] tag;
        logic [VAL_WIDTH-1:0] val;
    } operand_t;

    typedef struct packed {
        logic                  valid;
        logic [OP_WIDTH-1:0]   op;
        operand_t              j;
        operand_t              k;
        logic [TAG_WIDTH-1:0]  dest;
        logic [ADDR_WIDTH-1:0] pc;
    } rs_entry_t;

    // A pending operand takes the ALU broadcast first, then the LSB one.
    function automatic operand_t snoop(
        input operand_t             op,
        input logic                 a_rdy,
        input logic [TAG_WIDTH-1:0] a_tag,
        input logic [VAL_WIDTH-1:0] a_val,
        input logic                 l_rdy,
        input logic [TAG_WIDTH-1:0] l_tag,
        input logic [VAL_WIDTH-1:0] l_val
    );
        operand_t r;
        r = op;
        if (op.busy && a_rdy && (op.tag == a_tag)) begin
            r.busy = 1'b0;
            r.val  = a_val;
        end else if (op.busy && l_rdy && (op.tag == l_tag)) begin
            r.busy = 1'b0;
            r.val  = l_val;
        end else begin
            r = op;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_rs_prio_enc.sv
// Lowest-set-bit encoder with a found flag; used for free-slot and ready-slot picks.
module rs_prio_enc #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] idx
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = W'(i);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands are known,
// snoops ALU/LSB broadcasts and issues the lowest-index ready op each cycle.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE     = 8,
    parameter int RS_ID_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   flush,
    input  logic                   dispatch_valid,
    input  logic [OP_WIDTH-1:0]    dispatch_type,
    input  logic [VAL_WIDTH-1:0]   dispatch_vj,
    input  logic                   dispatch_qj_busy,
    input  logic [TAG_WIDTH-1:0]   dispatch_qj,
    input  logic [VAL_WIDTH-1:0]   dispatch_vk,
    input  logic                   dispatch_qk_busy,
    input  logic [TAG_WIDTH-1:0]   dispatch_qk,
    input  logic [TAG_WIDTH-1:0]   dispatch_entry,
    input  logic [ADDR_WIDTH-1:0]  dispatch_pc,
    input  logic                   alu_ready,
    input  logic [TAG_WIDTH-1:0]   alu_entry,
    input  logic [VAL_WIDTH-1:0]   alu_val,
    input  logic                   lsb_ready,
    input  logic [TAG_WIDTH-1:0]   lsb_entry,
    input  logic [VAL_WIDTH-1:0]   lsb_val,
    output logic                   rs_full,
    output logic [RS_ID_WIDTH:0]   rs_count,
    output logic                   execute,
    output logic [OP_WIDTH-1:0]    op_type,
    output logic [VAL_WIDTH-1:0]   val1,
    output logic [VAL_WIDTH-1:0]   val2,
    output logic [TAG_WIDTH-1:0]   entry,
    output logic [ADDR_WIDTH-1:0]  nowPC
);

    rs_entry_t entries_q [RS_SIZE];
    rs_entry_t entries_d [RS_SIZE];

    logic [RS_SIZE-1:0]     valid_s;
    logic [RS_SIZE-1:0]     free_req_s;
    logic [RS_SIZE-1:0]     ready_s;
    logic                   free_found_s;
    logic [RS_ID_WIDTH-1:0] free_idx_s;
    logic                   issue_found_s;
    logic [RS_ID_WIDTH-1:0] issue_idx_s;
    logic                   disp_take_s;
    operand_t               disp_j_s;
    operand_t               disp_k_s;
    rs_entry_t              new_entry_s;

    logic [RS_ID_WIDTH:0]   count_q,   count_d;
    logic                   execute_q, execute_d;
    logic [OP_WIDTH-1:0]    op_q,      op_d;
    logic [VAL_WIDTH-1:0]   val1_q,    val1_d;
    logic [VAL_WIDTH-1:0]   val2_q,    val2_d;
    logic [TAG_WIDTH-1:0]   dest_q,    dest_d;
    logic [ADDR_WIDTH-1:0]  pc_q,      pc_d;

    // Occupancy and readiness come from registered state only.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            valid_s[i]    = entries_q[i].valid;
            free_req_s[i] = ~entries_q[i].valid;
            ready_s[i]    = entries_q[i].valid & ~entries_q[i].j.busy & ~entries_q[i].k.busy;
        end
    end

    rs_prio_enc #(.N(RS_SIZE), .W(RS_ID_WIDTH)) u_free_sel (
        .req   (free_req_s),
        .found (free_found_s),
        .idx   (free_idx_s)
    );

    rs_prio_enc #(.N(RS_SIZE), .W(RS_ID_WIDTH)) u_issue_sel (
        .req   (ready_s),
        .found (issue_found_s),
        .idx   (issue_idx_s)
    );

    assign rs_full = &valid_s;

    // Next state: wakeup, issue, then dispatch into a slot free at cycle start.
    always_comb begin
        disp_j_s.busy = dispatch_qj_busy;
        disp_j_s.tag  = dispatch_qj;
        disp_j_s.val  = dispatch_vj;
        disp_k_s.busy = dispatch_qk_busy;
        disp_k_s.tag  = dispatch_qk;
        disp_k_s.val  = dispatch_vk;

        new_entry_s.valid = 1'b1;
        new_entry_s.op    = dispatch_type;
        new_entry_s.j     = snoop(disp_j_s, alu_ready, alu_entry, alu_val, lsb_ready, lsb_entry, lsb_val);
        new_entry_s.k     = snoop(disp_k_s, alu_ready, alu_entry, alu_val, lsb_ready, lsb_entry, lsb_val);
        new_entry_s.dest  = dispatch_entry;
        new_entry_s.pc    = dispatch_pc;

        disp_take_s = dispatch_valid & free_found_s;

        for (int i = 0; i < RS_SIZE; i++) begin
            entries_d[i] = entries_q[i];
            if (entries_q[i].valid) begin
                entries_d[i].j = snoop(entries_q[i].j, alu_ready, alu_entry, alu_val,
                                       lsb_ready, lsb_entry, lsb_val);
                entries_d[i].k = snoop(entries_q[i].k, alu_ready, alu_entry, alu_val,
                                       lsb_ready, lsb_entry, lsb_val);
            end else begin
                entries_d[i] = entries_q[i];
            end
        end

        execute_d = issue_found_s;
        op_d      = op_q;
        val1_d    = val1_q;
        val2_d    = val2_q;
        dest_d    = dest_q;
        pc_d      = pc_q;
        if (issue_found_s) begin
            op_d   = entries_q[issue_idx_s].op;
            val1_d = entries_q[issue_idx_s].j.val;
            val2_d = entries_q[issue_idx_s].k.val;
            dest_d = entries_q[issue_idx_s].dest;
            pc_d   = entries_q[issue_idx_s].pc;
            entries_d[issue_idx_s].valid = 1'b0;
        end else begin
            op_d = op_q;
        end

        if (disp_take_s) begin
            entries_d[free_idx_s] = new_entry_s;
        end else begin
            entries_d[free_idx_s] = entries_d[free_idx_s];
        end

        count_d = count_q + (RS_ID_WIDTH+1)'(disp_take_s) - (RS_ID_WIDTH+1)'(issue_found_s);
    end

    // State update: reset/flush dominate, rdy_in low freezes everything.
    always_ff @(posedge clk) begin
        if (rst_in || flush) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries_q[i] <= '0;
            end
            count_q   <= '0;
            execute_q <= 1'b0;
            op_q      <= '0;
            val1_q    <= '0;
            val2_q    <= '0;
            dest_q    <= '0;
            pc_q      <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries_q[i] <= entries_d[i];
            end
            count_q   <= count_d;
            execute_q <= execute_d;
            op_q      <= op_d;
            val1_q    <= val1_d;
            val2_q    <= val2_d;
            dest_q    <= dest_d;
            pc_q      <= pc_d;
        end
    end

    assign rs_count = count_q;
    assign execute  = execute_q;
    assign op_type  = op_q;
    assign val1     = val1_q;
    assign val2     = val2_q;
    assign entry    = dest_q;
    assign nowPC    = pc_q;

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: a slot-array reference model predicts every edge,
// a negedge monitor pops the prediction and compares all outputs.
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic clk = 1'b0;
    logic rst_in, rdy_in, flush;
    logic dispatch_valid, dispatch_qj_busy, dispatch_qk_busy;
    logic [OP_WIDTH-1:0]   dispatch_type;
    logic [VAL_WIDTH-1:0]  dispatch_vj, dispatch_vk;
    logic [TAG_WIDTH-1:0]  dispatch_qj, dispatch_qk, dispatch_entry;
    logic [ADDR_WIDTH-1:0] dispatch_pc;
    logic                  alu_ready, lsb_ready;
    logic [TAG_WIDTH-1:0]  alu_entry, lsb_entry;
    logic [VAL_WIDTH-1:0]  alu_val, lsb_val;
    logic                  rs_full, execute;
    logic [3:0]            rs_count;
    logic [OP_WIDTH-1:0]   op_type;
    logic [VAL_WIDTH-1:0]  val1, val2;
    logic [TAG_WIDTH-1:0]  entry;
    logic [ADDR_WIDTH-1:0] nowPC;

    alu_rs dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_type(dispatch_type),
        .dispatch_vj(dispatch_vj), .dispatch_qj_busy(dispatch_qj_busy), .dispatch_qj(dispatch_qj),
        .dispatch_vk(dispatch_vk), .dispatch_qk_busy(dispatch_qk_busy), .dispatch_qk(dispatch_qk),
        .dispatch_entry(dispatch_entry), .dispatch_pc(dispatch_pc),
        .alu_ready(alu_ready), .alu_entry(alu_entry), .alu_val(alu_val),
        .lsb_ready(lsb_ready), .lsb_entry(lsb_entry), .lsb_val(lsb_val),
        .rs_full(rs_full), .rs_count(rs_count), .execute(execute), .op_type(op_type),
        .val1(val1), .val2(val2), .entry(entry), .nowPC(nowPC)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                    exec;
        logic [OP_WIDTH-1:0]   op;
        logic [VAL_WIDTH-1:0]  v1, v2;
        logic [TAG_WIDTH-1:0]  dest;
        logic [ADDR_WIDTH-1:0] pc;
        int                    cnt;
        bit                    full;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    // Reference model: eight slots, plus the last issued bundle.
    bit                    mv[8], mjb[8], mkb[8];
    logic [OP_WIDTH-1:0]   mop[8];
    logic [VAL_WIDTH-1:0]  mvj[8], mvk[8];
    logic [TAG_WIDTH-1:0]  mqj[8], mqk[8], mdest[8];
    logic [ADDR_WIDTH-1:0] mpc[8];
    int                    mcnt = 0;
    bit                    l_exec = 1'b0;
    logic [OP_WIDTH-1:0]   l_op = '0;
    logic [VAL_WIDTH-1:0]  l_v1 = '0, l_v2 = '0;
    logic [TAG_WIDTH-1:0]  l_dest = '0;
    logic [ADDR_WIDTH-1:0] l_pc = '0;

    function automatic bit model_full();
        for (int i = 0; i < 8; i++) if (!mv[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wake(inout bit b, input logic [TAG_WIDTH-1:0] t, inout logic [VAL_WIDTH-1:0] v);
        if (b && alu_ready && t == alu_entry) begin b = 1'b0; v = alu_val; end
        else if (b && lsb_ready && t == lsb_entry) begin b = 1'b0; v = lsb_val; end
    endtask

    task automatic model_step();
        exp_t e;
        int iss = -1;
        int fr  = -1;
        if (rst_in || flush) begin
            for (int i = 0; i < 8; i++) mv[i] = 1'b0;
            mcnt = 0; l_exec = 1'b0; l_op = '0; l_v1 = '0; l_v2 = '0; l_dest = '0; l_pc = '0;
        end else if (rdy_in) begin
            for (int i = 0; i < 8; i++) if (fr < 0 && !mv[i]) fr = i;
            for (int i = 0; i < 8; i++) if (iss < 0 && mv[i] && !mjb[i] && !mkb[i]) iss = i;
            if (iss >= 0) begin
                l_exec = 1'b1; l_op = mop[iss]; l_v1 = mvj[iss]; l_v2 = mvk[iss];
                l_dest = mdest[iss]; l_pc = mpc[iss]; mv[iss] = 1'b0; mcnt--;
            end else begin
                l_exec = 1'b0;
            end
            for (int i = 0; i < 8; i++) if (mv[i]) begin
                wake(mjb[i], mqj[i], mvj[i]);
                wake(mkb[i], mqk[i], mvk[i]);
            end
            if (dispatch_valid && fr >= 0) begin
                mv[fr] = 1'b1; mop[fr] = dispatch_type; mdest[fr] = dispatch_entry; mpc[fr] = dispatch_pc;
                mjb[fr] = dispatch_qj_busy; mqj[fr] = dispatch_qj; mvj[fr] = dispatch_vj;
                mkb[fr] = dispatch_qk_busy; mqk[fr] = dispatch_qk; mvk[fr] = dispatch_vk;
                wake(mjb[fr], mqj[fr], mvj[fr]);
                wake(mkb[fr], mqk[fr], mvk[fr]);
                mcnt++;
            end
        end
        e.exec = l_exec; e.op = l_op; e.v1 = l_v1; e.v2 = l_v2; e.dest = l_dest; e.pc = l_pc;
        e.cnt = mcnt; e.full = model_full();
        sbq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one prediction per clock edge, compared half a cycle later.
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("execute",  32'(execute),  32'(e.exec));
            chk("rs_count", 32'(rs_count), 32'(e.cnt));
            chk("rs_full",  32'(rs_full),  32'(e.full));
            chk("op_type",  32'(op_type),  32'(e.op));
            chk("val1",     val1,          e.v1);
            chk("val2",     val2,          e.v2);
            chk("entry",    32'(entry),    32'(e.dest));
            chk("nowPC",    nowPC,         e.pc);
        end
    end

    task automatic tick();
        if (model_full()) dispatch_valid = 1'b0;
        model_step();
        @(posedge clk);
        #1;
        dispatch_valid = 1'b0; alu_ready = 1'b0; lsb_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic disp(input logic [OP_WIDTH-1:0] op, input logic [31:0] vj, input bit jb,
                        input logic [TAG_WIDTH-1:0] qj, input logic [31:0] vk, input bit kb,
                        input logic [TAG_WIDTH-1:0] qk, input logic [TAG_WIDTH-1:0] dst);
        dispatch_valid = 1'b1; dispatch_type = op;
        dispatch_vj = vj; dispatch_qj_busy = jb; dispatch_qj = qj;
        dispatch_vk = vk; dispatch_qk_busy = kb; dispatch_qk = qk;
        dispatch_entry = dst; dispatch_pc = 32'h1000 + 32'(dst) * 32'd4;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
        dispatch_valid = 1'b0; dispatch_type = '0; dispatch_vj = '0; dispatch_qj_busy = 1'b0;
        dispatch_qj = '0; dispatch_vk = '0; dispatch_qk_busy = 1'b0; dispatch_qk = '0;
        dispatch_entry = '0; dispatch_pc = '0;
        alu_ready = 1'b0; alu_entry = '0; alu_val = '0;
        lsb_ready = 1'b0; lsb_entry = '0; lsb_val = '0;
        idle(2);
        rst_in = 1'b0;
        idle(1);

        // addi with both operands ready
        disp(OP_ADDI_TYPE, 32'd5, 1'b0, 5'd0, 32'd7, 1'b0, 5'd0, 5'd3);
        tick(); idle(3);

        // wakeup from ALU, then dispatch bypass from LSB
        disp(OP_ADD_TYPE, 32'd0, 1'b1, 5'd2, 32'd1, 1'b0, 5'd0, 5'd4);
        tick();
        alu_ready = 1'b1; alu_entry = 5'd2; alu_val = 32'h10;
        tick(); idle(2);
        disp(OP_ADD_TYPE, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd5);
        lsb_ready = 1'b1; lsb_entry = 5'd6; lsb_val = 32'h55;
        tick(); idle(3);

        // fill all eight waiting on tag 9, then release; then dispatch under pressure
        for (int i = 0; i < 8; i++) begin
            disp(OP_BEQ_TYPE, 32'(i), 1'b1, 5'd9, 32'(i * 3), 1'b0, 5'd0, 5'(i + 8));
            tick();
        end
        alu_ready = 1'b1; alu_entry = 5'd9; alu_val = 32'hABCD;
        tick();
        for (int i = 0; i < 4; i++) begin
            disp(OP_ADDI_TYPE, 32'(i + 100), 1'b0, 5'd0, 32'd1, 1'b0, 5'd0, 5'(i + 20));
            tick();
        end
        idle(12);

        // flush with several valid entries and a live issue
        for (int i = 0; i < 5; i++) begin
            disp(OP_LW_TYPE, 32'd1, 1'b1, 5'd9, 32'd2, 1'b0, 5'd0, 5'(i + 1));
            tick();
        end
        disp(OP_ADDI_TYPE, 32'd77, 1'b0, 5'd0, 32'd88, 1'b0, 5'd0, 5'd30);
        tick(); tick();
        flush = 1'b1; alu_ready = 1'b1; alu_entry = 5'd9; alu_val = 32'h1;
        tick(); idle(3);

        // freeze with pending issue and broadcasts
        disp(OP_ADD_TYPE, 32'd1, 1'b1, 5'd9, 32'd2, 1'b0, 5'd0, 5'd11); tick();
        disp(OP_ADD_TYPE, 32'd3, 1'b0, 5'd0, 32'd4, 1'b0, 5'd0, 5'd12); tick();
        disp(OP_ADD_TYPE, 32'd5, 1'b0, 5'd0, 32'd6, 1'b0, 5'd0, 5'd13); tick();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alu_ready = 1'b1; alu_entry = 5'd9; alu_val = 32'h99;
            tick();
        end
        rdy_in = 1'b1;
        idle(4);
        alu_ready = 1'b1; alu_entry = 5'd9; alu_val = 32'h99;
        tick(); idle(3);

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            rdy_in = ($urandom_range(0, 9) != 0);
            flush  = ($urandom_range(0, 99) == 0);
            rst_in = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) < 6) begin
                disp(6'($urandom_range(1, 4)), $urandom, ($urandom_range(0, 1) == 1),
                     5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 2) == 0),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
                dispatch_pc = $urandom;
            end
            alu_ready = ($urandom_range(0, 2) == 0); alu_entry = 5'($urandom_range(0, 7)); alu_val = $urandom;
            lsb_ready = ($urandom_range(0, 2) == 0); lsb_entry = 5'($urandom_range(0, 7)); lsb_val = $urandom;
            tick();
            rst_in = 1'b0;
        end
        rdy_in = 1'b1;
        idle(4);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
